// File: rtl/coproc_control_unit.sv
// coproc_control_unit: job sequencer for the block-matrix-multiply coprocessor
// Accepts a job (r, c, mu), requests the memory bus, streams 2x2 A and B blocks into
// the register file, starts the PU once per inner step, then writes the C block back.
// Ports:
//   i_Clock / i_Reset                         clock, async active-low reset
//   i_Config                                  [7:0]=P, [15:8]=A base/4, [23:16]=B base/4, [31:24]=C base/4
//   i_Row_Index / i_Column_Index / i_mu       job indices, latched on accept
//   i_Indexes_Ready / o_Indexes_Received      job handshake (level in, 1-cycle pulse out)
//   i_Grant / o_Grant_Request                 memory bus arbitration
//   o_Memory_Read_Enable / o_Memory_Write_Enable / o_Memory_Address   memory port
//   o_RF_Address / o_RF_Write_Enable / o_RF_Read_Enable / o_AorB       register file port
//   o_PU_Start / i_Partial_Output_Ready       PU step handshake
//   o_Result_Ready                            job complete
// Optional: define CU_STICKY_RESULT_EN to hold o_Result_Ready until the next job is accepted.
module coproc_control_unit (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic [31:0] i_Config,
   input  logic [7:0]  i_Row_Index,
   input  logic [7:0]  i_Column_Index,
   input  logic [7:0]  i_mu,
   input  logic        i_Indexes_Ready,
   output logic        o_Indexes_Received,
   input  logic        i_Grant,
   output logic        o_Grant_Request,
   output logic        o_Memory_Read_Enable,
   output logic        o_Memory_Write_Enable,
   output logic [9:0]  o_Memory_Address,
   output logic [1:0]  o_RF_Address,
   output logic        o_RF_Write_Enable,
   output logic        o_RF_Read_Enable,
   output logic        o_AorB,
   output logic        o_PU_Start,
   input  logic        i_Partial_Output_Ready,
   output logic        o_Result_Ready
);
   typedef enum logic [2:0] {IDLE, REQ, LOAD_A, LOAD_B, START, WAIT_PU, WRITE, DONE} state_t;
   state_t     state, next_state;
   logic [2:0] count;
   logic [7:0] x, row, col, mu;
   logic [31:0] cfg;
   logic       rf_we_q, ack_q, result_q;
   logic [1:0] rf_waddr_q;
   logic       accept, loading, step, last_step, rd_en, wr_en, rf_re;
   logic [7:0] a_blk, b_blk, c_blk;
   logic [9:0] blk_base;
   logic [2:0] off;

   assign accept    = state == IDLE && i_Indexes_Ready;
   assign loading   = state == LOAD_A || state == LOAD_B;
   // the beat counter only advances while the bus is held
   assign step      = i_Grant && (loading || state == WRITE);
   assign last_step = {1'b0, x} + 9'd1 >= {1'b0, mu};
   // block indices only matter modulo 256 since each block spans 4 words of a 1024-word space
   assign a_blk     = row * mu + x;
   assign b_blk     = x * cfg[7:0] + col;
   assign c_blk     = row * cfg[7:0] + col;
   assign blk_base  = state == WRITE  ? {cfg[31:24], 2'b00} + {c_blk, 2'b00} :
                      state == LOAD_B ? {cfg[23:16], 2'b00} + {b_blk, 2'b00} :
                                        {cfg[15:8], 2'b00} + {a_blk, 2'b00};
   // memory writes trail the RF reads by one beat
   assign off       = state == WRITE ? count - 3'd1 : count;

   always_ff @(posedge i_Clock or negedge i_Reset)
      if (!i_Reset) state <= IDLE;
      else state <= next_state;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept && i_mu != 8'd0) next_state = REQ;
         REQ:     if (i_Grant) next_state = LOAD_A;
         LOAD_A:  if (step && count == 3'd4) next_state = LOAD_B;
         LOAD_B:  if (step && count == 3'd4) next_state = START;
         START:   next_state = WAIT_PU;
         WAIT_PU: if (i_Partial_Output_Ready) next_state = last_step ? WRITE : LOAD_A;
         WRITE:   if (step && count == 3'd4) next_state = DONE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset)
      if (!i_Reset) begin
         count      <= 3'd0;
         x          <= 8'd0;
         row        <= 8'd0;
         col        <= 8'd0;
         mu         <= 8'd0;
         cfg        <= 32'd0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= 2'd0;
         ack_q      <= 1'b0;
         result_q   <= 1'b0;
      end else begin
         ack_q      <= accept;
         // RF write is the registered echo of the read issued last cycle, so it lands even if the grant drops
         rf_we_q    <= rd_en;
         rf_waddr_q <= count[1:0];
         count      <= step ? (count == 3'd4 ? 3'd0 : count + 3'd1) : (loading || state == WRITE) ? count : 3'd0;
         if (accept) begin
            row <= i_Row_Index;
            col <= i_Column_Index;
            mu  <= i_mu;
            cfg <= i_Config;
            x   <= 8'd0;
         end else if (state == WAIT_PU && i_Partial_Output_Ready && !last_step) x <= x + 8'd1;
`ifdef CU_STICKY_RESULT_EN
         result_q   <= next_state == DONE || (accept && i_mu == 8'd0) || (result_q && !accept);
`else
         result_q   <= next_state == DONE || (accept && i_mu == 8'd0);
`endif
      end

   always_comb begin
      rd_en                 = i_Grant && loading && count <= 3'd3;
      rf_re                 = i_Grant && state == WRITE && count <= 3'd3;
      wr_en                 = i_Grant && state == WRITE && count != 3'd0;
      o_Grant_Request       = state != IDLE;
      o_Memory_Read_Enable  = rd_en;
      o_Memory_Write_Enable = wr_en;
      o_Memory_Address      = (rd_en || wr_en) ? blk_base + {7'd0, off} : 10'd0;
      o_RF_Read_Enable      = rf_re;
      o_RF_Write_Enable     = rf_we_q;
      o_RF_Address          = rf_re ? count[1:0] : rf_we_q ? rf_waddr_q : 2'd0;
      o_AorB                = state == LOAD_B;
      o_PU_Start            = state == START;
      o_Indexes_Received    = ack_q;
      o_Result_Ready        = result_q;
   end
endmodule

// File: tb/tb_coproc_control_unit.sv
// tb_coproc_control_unit: randomized jobs checked against a transaction-level model of the sequencer
module tb_coproc_control_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] i_Config = 32'd0;
   logic [7:0]  i_Row_Index = 8'd0, i_Column_Index = 8'd0, i_mu = 8'd0;
   logic        i_Indexes_Ready = 1'b0, i_Grant = 1'b0, i_Partial_Output_Ready = 1'b0;
   logic        o_Indexes_Received, o_Grant_Request, o_Memory_Read_Enable, o_Memory_Write_Enable;
   logic [9:0]  o_Memory_Address;
   logic [1:0]  o_RF_Address;
   logic        o_RF_Write_Enable, o_RF_Read_Enable, o_AorB, o_PU_Start, o_Result_Ready;
   logic [20:0] outs;
   int          n_chk = 0, n_err = 0;
   logic [10:0] rd_q[$];
   logic [9:0]  wr_q[$];
   int          pu_n = 0, res_n = 0;
   logic        p_re = 1'b0, p_res = 1'b0, p_ab = 1'b0;
   logic [9:0]  p_addr = 10'd0;
`ifdef CU_STICKY_RESULT_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   coproc_control_unit dut (
      .i_Clock(clk), .i_Reset(rst_n), .i_Config(i_Config), .i_Row_Index(i_Row_Index),
      .i_Column_Index(i_Column_Index), .i_mu(i_mu), .i_Indexes_Ready(i_Indexes_Ready),
      .o_Indexes_Received(o_Indexes_Received), .i_Grant(i_Grant), .o_Grant_Request(o_Grant_Request),
      .o_Memory_Read_Enable(o_Memory_Read_Enable), .o_Memory_Write_Enable(o_Memory_Write_Enable),
      .o_Memory_Address(o_Memory_Address), .o_RF_Address(o_RF_Address),
      .o_RF_Write_Enable(o_RF_Write_Enable), .o_RF_Read_Enable(o_RF_Read_Enable), .o_AorB(o_AorB),
      .o_PU_Start(o_PU_Start), .i_Partial_Output_Ready(i_Partial_Output_Ready),
      .o_Result_Ready(o_Result_Ready)
   );

   always #5 clk = ~clk;

   assign outs = {o_Indexes_Received, o_Grant_Request, o_Memory_Read_Enable, o_Memory_Write_Enable,
                  o_Memory_Address, o_RF_Address, o_RF_Write_Enable, o_RF_Read_Enable, o_AorB,
                  o_PU_Start, o_Result_Ready};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // bus monitor: records the transaction stream and checks the RF write echo rule every cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         p_re  = 1'b0;
         p_res = 1'b0;
      end else begin
         if (o_RF_Write_Enable || p_re) chk("rf_we_follows_read", o_RF_Write_Enable, p_re);
         if (o_RF_Write_Enable && p_re) begin
            chk("rf_waddr", o_RF_Address, p_addr % 4);
            chk("rf_bank", o_AorB, p_ab);
         end
         if (o_Memory_Read_Enable || o_Memory_Write_Enable) chk("strobe_needs_grant", i_Grant, 1);
         if (o_Memory_Read_Enable) rd_q.push_back({o_AorB, o_Memory_Address});
         if (o_Memory_Write_Enable) wr_q.push_back(o_Memory_Address);
         if (o_PU_Start) pu_n++;
         if (o_Result_Ready && !p_res) res_n++;
         p_re   = o_Memory_Read_Enable;
         p_addr = o_Memory_Address;
         p_ab   = o_AorB;
         p_res  = o_Result_Ready;
      end
   end

   // called and returns just after a rising edge with the DUT idle
   task automatic run_job(input logic [31:0] cfg, input logic [7:0] r, input logic [7:0] c,
                          input logic [7:0] m, input int gp, input int hold, input int drop_addr);
      logic [10:0] exp_rd[$];
      logic [9:0]  exp_wr[$];
      int p, ab, bb, cb, res0, dly, drop_left, cyc;
      bit dropped;
      p = int'(cfg[7:0]); ab = int'(cfg[15:8]); bb = int'(cfg[23:16]); cb = int'(cfg[31:24]);
      dly = 0; drop_left = 0; cyc = 0; dropped = 1'b0;
      for (int x = 0; x < int'(m); x++) begin
         for (int k = 0; k < 4; k++) exp_rd.push_back({1'b0, 10'((ab * 4 + 4 * (int'(r) * int'(m) + x) + k) % 1024)});
         for (int k = 0; k < 4; k++) exp_rd.push_back({1'b1, 10'((bb * 4 + 4 * (x * p + int'(c)) + k) % 1024)});
      end
      for (int k = 0; k < 4; k++) exp_wr.push_back(10'((cb * 4 + 4 * (int'(r) * p + int'(c)) + k) % 1024));
      rd_q.delete();
      wr_q.delete();
      pu_n = 0;
      res0 = res_n;
      i_Config = cfg; i_Row_Index = r; i_Column_Index = c; i_mu = m;
      i_Indexes_Ready = 1'b1; i_Grant = 1'b0; i_Partial_Output_Ready = 1'b0;
      @(posedge clk) #1;
      i_Indexes_Ready = 1'b0;
      chk("ack_pulse", o_Indexes_Received, 1);
      if (m == 8'd0) begin
         chk("mu0_result", o_Result_Ready, 1);
         chk("mu0_no_request", o_Grant_Request, 0);
         @(posedge clk) #1;
         chk("mu0_ack_drop", o_Indexes_Received, 0);
         chk("mu0_result_after", o_Result_Ready, STICKY);
         chk("mu0_no_request_after", o_Grant_Request, 0);
         chk("mu0_no_reads", rd_q.size(), 0);
         return;
      end
      chk("result_clear_on_accept", o_Result_Ready, 0);
      chk("request_up", o_Grant_Request, 1);
      for (int h = 0; h < hold; h++) begin
         chk("req_held_no_grant", o_Grant_Request, 1);
         chk("no_strobe_no_grant", {o_Memory_Read_Enable, o_Memory_Write_Enable, o_RF_Write_Enable}, 0);
         @(posedge clk) #1;
         if (h == 0) chk("ack_one_cycle", o_Indexes_Received, 0);
      end
      while (res_n == res0 && cyc < 3000) begin
         if (drop_addr >= 0 && !dropped && o_Memory_Read_Enable && int'(o_Memory_Address) == drop_addr) begin
            dropped = 1'b1;
            drop_left = 3;
         end
         i_Grant = drop_left > 0 ? 1'b0 : ($urandom_range(0, 99) < gp);
         if (drop_left > 0) drop_left--;
         if (o_PU_Start) begin
            i_Partial_Output_Ready = 1'b0;
            dly = $urandom_range(1, 4);
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) i_Partial_Output_Ready = 1'b1;
         end
         @(posedge clk) #1;
         cyc++;
      end
      chk("job_done_seen", res_n != res0, 1);
      chk("req_dropped_after_done", o_Grant_Request, 0);
      chk("result_after_done", o_Result_Ready, STICKY);
      chk("pu_start_count", pu_n, m);
      chk("read_count", rd_q.size(), exp_rd.size());
      for (int i = 0; i < exp_rd.size(); i++)
         if (i < rd_q.size()) chk("read_addr_bank", rd_q[i], exp_rd[i]);
      chk("write_count", wr_q.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < wr_q.size()) chk("write_addr", wr_q[i], exp_wr[i]);
      if (drop_addr >= 0) chk("grant_drop_hit", dropped, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs, 0);
      rst_n = 1'b1;
      @(posedge clk) #1;
      chk("idle_outputs", outs, 0);
      run_job(32'h80401008, 8'd5, 8'd6, 8'd3, 100, 5, 126);
      run_job(32'h80401008, 8'd5, 8'd6, 8'd0, 100, 0, -1);
      run_job(32'h80401008, 8'd5, 8'd6, 8'd1, 70, 2, -1);
      for (int j = 0; j < 16; j++)
         run_job($urandom(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 4)), $urandom_range(40, 100), $urandom_range(0, 3), -1);
      run_job(32'hFFFFFF0F, 8'd255, 8'd255, 8'd4, 80, 1, -1);
      // asynchronous reset in the middle of a job
      i_Config = 32'h80401008; i_Row_Index = 8'd5; i_Column_Index = 8'd6; i_mu = 8'd2;
      i_Indexes_Ready = 1'b1; i_Grant = 1'b1;
      @(posedge clk) #1;
      i_Indexes_Ready = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (o_AorB && o_Memory_Read_Enable) break;
         @(posedge clk) #1;
      end
      chk("reach_load_b", o_AorB && o_Memory_Read_Enable, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", outs, 0);
      @(posedge clk) #1;
      chk("reset_held_outputs", outs, 0);
      rst_n = 1'b1;
      @(posedge clk) #1;
      chk("post_reset_idle", outs, 0);
      run_job(32'h80401008, 8'd5, 8'd6, 8'd2, 90, 0, -1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/coproc_control_unit.md
Name: coproc_control_unit

Overview:
Sequencer for the block-matrix-multiply coprocessor. It accepts a job (row block index, column block index, inner block count mu) and arbitrates for the shared memory bus. It then streams 2x2 operand blocks A and B from memory into the register file (RF), starts the processing unit (PU) once per inner step, and finally writes the 2x2 result block back to memory. Blocks are 4 consecutive memory words.

Parameters:
None; widths are fixed by the ports.

Ports:
i_Clock  in  1  system clock, rising edge
i_Reset  in  1  asynchronous active-low reset
i_Config  in  32  [7:0]=P, B/C block-columns; [15:8]=A base/4; [23:16]=B base/4; [31:24]=C base/4
i_Row_Index  in  8  result block row r
i_Column_Index  in  8  result block column c
i_mu  in  8  inner block count
i_Indexes_Ready  in  1  job valid (level)
o_Indexes_Received  out  1  one-cycle job-accept pulse
i_Grant  in  1  memory bus granted
o_Grant_Request  out  1  memory bus request
o_Memory_Read_Enable  out  1  memory read strobe; data returns next cycle
o_Memory_Write_Enable  out  1  memory write strobe
o_Memory_Address  out  10  word address
o_RF_Address  out  2  RF word index 0..3
o_RF_Write_Enable  out  1  RF write strobe
o_RF_Read_Enable  out  1  RF/result read strobe
o_AorB  out  1  0 = A bank, 1 = B bank
o_PU_Start  out  1  one-cycle PU start pulse
i_Partial_Output_Ready  in  1  PU step complete (level)
o_Result_Ready  out  1  job complete

Behaviour:
- Reset (async, i_Reset=0): state IDLE; all outputs 0; r_x=0; r_Clock_Count=0. Indexes are latched only in IDLE.
- State IDLE: when i_Indexes_Ready=1, latch r, c, mu; pulse o_Indexes_Received for 1 cycle.
  - mu=0: pulse o_Result_Ready and stay in IDLE; no bus activity.
  - Otherwise: r_x=0, go to REQ.
- State REQ: assert o_Grant_Request. It stays high through DONE. Go to LOAD_A when i_Grant=1.
- State LOAD_A (o_AorB=0) and LOAD_B (o_AorB=1): r_Clock_Count runs 0..4.
  - Counts 0..3: o_Memory_Read_Enable=1, address = block base + count.
  - Counts 1..4: o_RF_Write_Enable=1, o_RF_Address = count-1. This strobe is a registered copy of the previous cycle's read enable.
  - A block base = Abase*4 + 4*(r*mu + r_x). B block base = Bbase*4 + 4*(r_x*P + c).
  - All address arithmetic is modulo 1024.
  - LOAD_A goes to LOAD_B; LOAD_B goes to START.
- State START: o_PU_Start=1 for one cycle, then WAIT_PU.
- State WAIT_PU: wait for i_Partial_Output_Ready=1. It is sampled no earlier than the cycle after the start pulse.
  - If r_x < mu-1: r_x++, go to LOAD_A.
  - Otherwise go to WRITE.
- State WRITE: r_Clock_Count runs 0..4.
  - Counts 0..3: o_RF_Read_Enable=1, o_RF_Address = count.
  - Counts 1..4: o_Memory_Write_Enable=1, address = Cbase*4 + 4*(r*P + c) + count-1.
  - Then go to DONE.
- State DONE: o_Result_Ready=1 for one cycle; drop o_Grant_Request; go to IDLE. A still-high i_Indexes_Ready starts a new job on the next cycle.
- Grant loss: if i_Grant=0 in LOAD_A, LOAD_B or WRITE, stall.
  - Counter and state hold; memory enables and RF enables issued for new reads are forced to 0.
  - A registered RF write from a read issued in the previous cycle still completes.
  - On re-grant, resume at the held count, re-issuing the current read or write.
- Inputs other than i_Grant and i_Partial_Output_Ready are ignored outside IDLE.

Optional Feature:
CU_STICKY_RESULT_EN.
- Defined: o_Result_Ready is held high from DONE until the next job is accepted in IDLE. It clears in the same cycle as o_Indexes_Received.
- Undefined: o_Result_Ready is a one-cycle pulse.

Test Plan:
- Reset: drive i_Reset low mid-job (e.g., in LOAD_B) -> all outputs 0 immediately, state IDLE.
- Job intake: i_Config=32'h80401008, r=5, c=6, mu=3, i_Indexes_Ready=1 -> 1-cycle o_Indexes_Received; o_Grant_Request=1 and held with no memory strobes until i_Grant=1 (applied 5 cycles later).
- Addressing:
  - First LOAD_A reads addresses 124..127.
  - First LOAD_B reads 280..283 with o_AorB=1.
  - RF writes at addresses 0..3, each one cycle after its read.
- Accumulate loop: i_Partial_Output_Ready held 1 -> exactly 3 o_PU_Start pulses (r_x=0,1,2); the third LOAD_A reads 132..135.
- Writeback: after the last step, memory writes to 696..699; then o_Result_Ready pulse and o_Grant_Request=0.
- Edges:
  - mu=0: immediate o_Result_Ready, no request.
  - i_Grant dropped for 3 cycles at LOAD_A count 2: resumes re-reading address base+2; no duplicate or missing RF write.
